// File: rtl/fb_fill_writer.sv
// Frame-buffer rectangle fill engine: writes one 12-bit colour over a clipped
// screen rectangle, row-major, one word per accepted memory cycle.
module fb_fill_writer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [9:0]        x0,
    input  logic [9:0]        y0,
    input  logic [9:0]        w,
    input  logic [9:0]        h,
    input  logic [11:0]       color,
    output logic              busy,
    output logic              done,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready
);

    // state  | meaning
    // IDLE   | waiting for start; inputs sampled here only
    // SETUP  | clip rectangle, form first row base and address
    // WRITE  | mem_wr asserted; advance on each accepted word
    // DONE   | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [10:0]       SW11   = 11'(SCREEN_WIDTH);
    localparam logic [10:0]       SH11   = 11'(SCREEN_HEIGHT);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(SCREEN_WIDTH);

    state_t            state;
    logic [9:0]        x0_q;
    logic [9:0]        y0_q;
    logic [9:0]        w_q;
    logic [9:0]        h_q;
    logic [11:0]       color_q;
    logic [10:0]       x_cur;
    logic [10:0]       y_cur;
    logic [10:0]       x_last;
    logic [10:0]       y_last;
    logic [ADDR_W-1:0] row_base;

    logic [10:0]       x_end_raw;
    logic [10:0]       y_end_raw;
    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic              rect_empty;
    logic [ADDR_W-1:0] row_base_init;
    logic [ADDR_W-1:0] addr_init;
    logic [ADDR_W-1:0] row_base_step;
    logic [ADDR_W-1:0] addr_next_row;

    // 11-bit sums cannot overflow for 10-bit operands
    always_comb begin
        x_end_raw     = {1'b0, x0_q} + {1'b0, w_q};
        y_end_raw     = {1'b0, y0_q} + {1'b0, h_q};
        x_end         = (x_end_raw > SW11) ? SW11 : x_end_raw;
        y_end         = (y_end_raw > SH11) ? SH11 : y_end_raw;
        rect_empty    = (w_q == 10'd0) || (h_q == 10'd0) ||
                        ({1'b0, x0_q} >= SW11) || ({1'b0, y0_q} >= SH11);
        row_base_init = ADDR_W'(y0_q) * STRIDE;
        addr_init     = row_base_init + ADDR_W'(x0_q);
        row_base_step = row_base + STRIDE;
        addr_next_row = row_base_step + ADDR_W'(x0_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            x_cur     <= '0;
            y_cur     <= '0;
            x_last    <= '0;
            y_last    <= '0;
            row_base  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x0_q    <= x0;
                        y0_q    <= y0;
                        w_q     <= w;
                        h_q     <= h;
                        color_q <= color;
                        busy    <= 1'b1;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (rect_empty) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        x_cur     <= {1'b0, x0_q};
                        y_cur     <= {1'b0, y0_q};
                        x_last    <= x_end - 11'd1;
                        y_last    <= y_end - 11'd1;
                        row_base  <= row_base_init;
                        mem_addr  <= addr_init;
                        mem_wdata <= {{(DATA_W-12){1'b0}}, color_q};
                        mem_wr    <= 1'b1;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // address and data hold while the arbiter stalls
                    if (mem_ready) begin
                        if (x_cur != x_last) begin
                            x_cur    <= x_cur + 11'd1;
                            mem_addr <= mem_addr + 1'b1;
                        end else if (y_cur != y_last) begin
                            x_cur    <= {1'b0, x0_q};
                            y_cur    <= y_cur + 11'd1;
                            row_base <= row_base_step;
                            mem_addr <= addr_next_row;
                        end else begin
                            mem_wr <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
